// File: rtl/fpu_pkg.sv
// Shared constants for the FPU issue queue: precision-derived field sizes,
// op codes and result flag bit positions.
package fpu_pkg;

    localparam int OP_W    = 3;
    localparam int RMODE_W = 2;
    localparam int FLAG_W  = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    // Flag vector is {snan,qnan,inf,ine,overflow,underflow,div_by_zero,zero}.
    localparam int FLAG_SNAN = 7;
    localparam int FLAG_QNAN = 6;
    localparam int FLAG_INF  = 5;
    localparam int FLAG_INE  = 4;
    localparam int FLAG_OVF  = 3;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_DBZ  = 1;
    localparam int FLAG_ZERO = 0;

    // Precision select: 0 = double, 1 = single, 2 = half.
    function automatic int fpu_width(input int fpu_type);
        return 16 << (2 - fpu_type);
    endfunction

    function automatic int fpu_exp_size(input int fpu_type);
        case (fpu_type)
            0:       return 11;
            1:       return 8;
            default: return 5;
        endcase
    endfunction

    function automatic int fpu_mant_size(input int fpu_type);
        case (fpu_type)
            0:       return 52;
            1:       return 23;
            default: return 10;
        endcase
    endfunction

    function automatic int fpu_bias(input int fpu_type);
        return (1 << (fpu_exp_size(fpu_type) - 1)) - 1;
    endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous FIFO with a registered head word and occupancy count;
// push-when-full and pop-when-empty are ignored.
module fpu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_next_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && (count_r != CW'(DEPTH));
    assign pop_ok_s  = pop && (count_r != {CW{1'b0}});

    // Next head: the following stored entry on pop, or the incoming word when it lands at the front.
    always_comb begin
        head_next_s = head_r;
        if (pop_ok_s) begin
            if (count_r == CW'(1)) begin
                head_next_s = push_ok_s ? wdata : head_r;
            end else begin
                head_next_s = mem_r[rd_ptr_r + AW'(1)];
            end
        end else if (push_ok_s && (count_r == {CW{1'b0}})) begin
            head_next_s = wdata;
        end else begin
            head_next_s = head_r;
        end
    end

    // Storage, pointers (wrap naturally at power-of-two depth) and count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
            head_r  <= head_next_s;
        end
    end

    assign head  = head_r;
    assign count = count_r;

endmodule

// File: rtl/fpu_issue_queue.sv
// Decouples requesters from a fixed-latency FPU core: input queue, credit-based
// issue, valid shift register tracking in-flight ops, and an in-order result queue.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int FPU_TYPE = 1,
    parameter int DEPTH    = 4,
    parameter int FPU_LAT  = 4,
    localparam int W = fpu_width(FPU_TYPE)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [1:0]   in_rmode,
    input  logic [W-1:0] in_opa,
    input  logic [W-1:0] in_opb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    output logic [7:0]   out_flags,
    output logic [2:0]   fpu_op,
    output logic [1:0]   fpu_rmode,
    output logic [W-1:0] fpu_opa,
    output logic [W-1:0] fpu_opb,
    input  logic [W-1:0] fpu_out,
    input  logic [7:0]   fpu_flags,
    output logic         busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = OP_W + RMODE_W + 2 * W;
    localparam int OW = W + FLAG_W;

    logic [IW-1:0]      in_head_s;
    logic [CW-1:0]      in_count_s;
    logic [OW-1:0]      out_head_s;
    logic [CW-1:0]      out_count_s;
    logic               in_push_s;
    logic               out_pop_s;
    logic               issue_s;
    logic               capture_s;
    logic [FPU_LAT-1:0] vsr_r;
    logic [FPU_LAT-1:0] vsr_next_s;
    logic [2:0]         fpu_op_r;
    logic [1:0]         fpu_rmode_r;
    logic [W-1:0]       fpu_opa_r;
    logic [W-1:0]       fpu_opb_r;

    function automatic int count_ones(input logic [FPU_LAT-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < FPU_LAT; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    assign in_ready  = (in_count_s < CW'(DEPTH));
    assign in_push_s = in_valid && in_ready;
    assign out_valid = (out_count_s != {CW{1'b0}});
    assign out_pop_s = out_valid && out_ready;

    // Only issue when the result queue is guaranteed a slot on return.
    assign issue_s = (in_count_s != {CW{1'b0}}) &&
                     ((int'(out_count_s) + count_ones(vsr_r)) < DEPTH);

    assign vsr_next_s = (vsr_r << 1'b1) | FPU_LAT'(issue_s);
    assign capture_s  = vsr_r[FPU_LAT-1];

    fpu_sync_fifo #(.WIDTH(IW), .DEPTH(DEPTH)) u_in_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_push_s),
        .wdata ({in_op, in_rmode, in_opa, in_opb}),
        .pop   (issue_s),
        .head  (in_head_s),
        .count (in_count_s)
    );

    fpu_sync_fifo #(.WIDTH(OW), .DEPTH(DEPTH)) u_out_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture_s),
        .wdata ({fpu_out, fpu_flags}),
        .pop   (out_pop_s),
        .head  (out_head_s),
        .count (out_count_s)
    );

    // In-flight tracker; cleared on reset so results already in the core are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsr_r <= {FPU_LAT{1'b0}};
        end else begin
            vsr_r <= vsr_next_s;
        end
    end

    // Core operand registers, loaded from the input queue head on issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpu_op_r    <= 3'd0;
            fpu_rmode_r <= 2'd0;
            fpu_opa_r   <= {W{1'b0}};
            fpu_opb_r   <= {W{1'b0}};
        end else if (issue_s) begin
            fpu_op_r    <= in_head_s[IW-1 -: 3];
            fpu_rmode_r <= in_head_s[IW-4 -: 2];
            fpu_opa_r   <= in_head_s[2*W-1 -: W];
            fpu_opb_r   <= in_head_s[W-1:0];
        end else begin
            fpu_op_r    <= fpu_op_r;
            fpu_rmode_r <= fpu_rmode_r;
            fpu_opa_r   <= fpu_opa_r;
            fpu_opb_r   <= fpu_opb_r;
        end
    end

    assign fpu_op    = fpu_op_r;
    assign fpu_rmode = fpu_rmode_r;
    assign fpu_opa   = fpu_opa_r;
    assign fpu_opb   = fpu_opb_r;
    assign out_res   = out_head_s[OW-1:FLAG_W];
    assign out_flags = out_head_s[FLAG_W-1:0];
    assign busy      = (in_count_s != {CW{1'b0}}) || out_valid || (|vsr_r);

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed and randomised checks of fpu_issue_queue against a bench-side core
// model and an acceptance-order scoreboard.
module tb_fpu_issue_queue;

    localparam int DEPTH = 4;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  in_op, fpu_op;
    logic [1:0]  in_rmode, fpu_rmode;
    logic [31:0] in_opa, in_opb, out_res, fpu_opa, fpu_opb, fpu_out;
    logic [7:0]  out_flags, fpu_flags;

    logic        h16_in_valid, h16_in_ready, h16_out_valid, h16_busy;
    logic [2:0]  h16_fpu_op;
    logic [1:0]  h16_fpu_rmode;
    logic [15:0] h16_out_res, h16_fpu_opa, h16_fpu_opb, h16_fpu_out;
    logic [7:0]  h16_out_flags;
    logic        h64_in_valid, h64_in_ready, h64_out_valid, h64_busy;
    logic [2:0]  h64_fpu_op;
    logic [1:0]  h64_fpu_rmode;
    logic [63:0] h64_out_res, h64_fpu_opa, h64_fpu_opb, h64_fpu_out;
    logic [7:0]  h64_out_flags;

    int vectors = 0;
    int miscompares = 0;
    int n_acc = 0;
    int n_pop = 0;
    bit rnd = 1'b0;
    logic [39:0] sb [$];
    logic        held = 1'b0;
    logic [39:0] held_val;
    logic [39:0] core_s, pipe0, pipe1, pipe2;

    always #5 clk = ~clk;

    fpu_issue_queue #(.FPU_TYPE(1), .DEPTH(DEPTH), .FPU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rmode(in_rmode), .in_opa(in_opa), .in_opb(in_opb),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags),
        .fpu_op(fpu_op), .fpu_rmode(fpu_rmode), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
        .fpu_out(fpu_out), .fpu_flags(fpu_flags), .busy(busy)
    );

    fpu_issue_queue #(.FPU_TYPE(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(h16_in_valid), .in_ready(h16_in_ready),
        .in_op(3'd0), .in_rmode(2'd0), .in_opa(16'h3c00), .in_opb(16'h3c00),
        .out_valid(h16_out_valid), .out_ready(1'b1), .out_res(h16_out_res), .out_flags(h16_out_flags),
        .fpu_op(h16_fpu_op), .fpu_rmode(h16_fpu_rmode), .fpu_opa(h16_fpu_opa), .fpu_opb(h16_fpu_opb),
        .fpu_out(h16_fpu_out), .fpu_flags(8'h00), .busy(h16_busy)
    );

    fpu_issue_queue #(.FPU_TYPE(0)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(h64_in_valid), .in_ready(h64_in_ready),
        .in_op(3'd0), .in_rmode(2'd0), .in_opa(64'h3ff0000000000000), .in_opb(64'h3ff0000000000000),
        .out_valid(h64_out_valid), .out_ready(1'b1), .out_res(h64_out_res), .out_flags(h64_out_flags),
        .fpu_op(h64_fpu_op), .fpu_rmode(h64_fpu_rmode), .fpu_opa(h64_fpu_opa), .fpu_opb(h64_fpu_opb),
        .fpu_out(h64_fpu_out), .fpu_flags(8'h00), .busy(h64_busy)
    );

    // Single-op cores for the half/double builds: operands hold after issue, so combinational is enough.
    assign h16_fpu_out = (h16_fpu_op == 3'd0 && h16_fpu_opa == 16'h3c00 && h16_fpu_opb == 16'h3c00)
                         ? 16'h4000 : 16'hdead;
    assign h64_fpu_out = (h64_fpu_op == 3'd0 && h64_fpu_opa == 64'h3ff0000000000000 &&
                          h64_fpu_opb == 64'h3ff0000000000000) ? 64'h4000000000000000 : 64'hdead;

    // Reference core behaviour: two exact IEEE cases, otherwise a deterministic mix of the inputs.
    function automatic logic [39:0] core_f(input logic [2:0] op, input logic [1:0] rm,
                                           input logic [31:0] a, input logic [31:0] b);
        if (op == 3'd2 && a == 32'h3f800000 && b == 32'h40000000) return {32'h40000000, 8'h00};
        if (op == 3'd3 && a == 32'h3f800000 && b == 32'h00000000) return {32'h7f800000, 8'h22};
        return {a ^ {b[15:0], b[31:16]} ^ {27'd0, op, rm}, a[31:24] ^ b[7:0] ^ {op, rm, 3'b101}};
    endfunction

    // Core pipeline: LAT-1 register stages after the DUT's operand registers.
    assign core_s = core_f(fpu_op, fpu_rmode, fpu_opa, fpu_opb);
    always @(posedge clk) begin
        pipe0 <= core_s;
        pipe1 <= pipe0;
        pipe2 <= pipe1;
    end
    assign fpu_out   = pipe2[39:8];
    assign fpu_flags = pipe2[7:0];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: record accepted requests, check every result leaving and held stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 72'(out_valid), 72'(1'b1));
                chk("hold_data", 72'({out_res, out_flags}), 72'(held_val));
            end
            if (in_valid && in_ready) begin
                sb.push_back(core_f(in_op, in_rmode, in_opa, in_opb));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 72'(sb.size() != 0), 72'(1'b1));
                if (sb.size() != 0) chk("result", 72'({out_res, out_flags}), 72'(sb.pop_front()));
                n_pop++;
            end
            held     = out_valid && !out_ready;
            held_val = {out_res, out_flags};
        end
    end

    task automatic send(input logic [2:0] op, input logic [1:0] rm, input logic [31:0] a,
                        input logic [31:0] b, input int budget, output bit ok);
        in_valid = 1'b1; in_op = op; in_rmode = rm; in_opa = a; in_opb = b;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            done = !busy;
        end
        chk({tag, "_busy"}, 72'(busy), 72'(1'b0));
        chk({tag, "_sb"}, 72'(sb.size()), 72'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int base_acc, base_pop, n_stuck;
        logic [15:0] r16;
        logic [63:0] r64;
        logic [7:0]  f16, f64;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_rmode = 2'd0; in_opa = 32'd0; in_opb = 32'd0;
        h16_in_valid = 1'b0; h64_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 72'(in_ready), 72'(1'b1));
        chk("rst_out_valid", 72'(out_valid), 72'(1'b0));
        chk("rst_busy", 72'(busy), 72'(1'b0));
        chk("rst_fpu_op", 72'({fpu_op, fpu_rmode}), 72'(5'd0));
        chk("rst_fpu_opa", 72'(fpu_opa), 72'(32'd0));
        chk("rst_fpu_opb", 72'(fpu_opb), 72'(32'd0));
        @(posedge clk);
        #1;

        // Minimum latency with a 1.0 * 2.0 multiply.
        out_ready = 1'b1;
        send(3'd2, 2'd0, 32'h3f800000, 32'h40000000, 10, ok);
        chk("mul_accept", 72'(ok), 72'(1'b1));
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("latency_valid", 72'(out_valid), 72'(k == 5));
        end
        @(posedge clk);
        #1;
        send(3'd3, 2'd0, 32'h3f800000, 32'h00000000, 10, ok);
        chk("div_accept", 72'(ok), 72'(1'b1));
        wait_drain("div");

        // Ten requests against a stalled output: only 2*DEPTH may be accepted.
        out_ready = 1'b0;
        base_acc = n_acc;
        base_pop = n_pop;
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 2'(i), 32'h1000 + 32'(i), 32'h0abc0000 + 32'(i), 10, ok);
            chk("burst_accept", 72'(ok), 72'(1'b1));
        end
        send(3'd5, 2'd1, 32'h2008, 32'h3008, 10, ok);
        chk("stall_accept", 72'(ok), 72'(1'b0));
        chk("stall_ready", 72'(in_ready), 72'(1'b0));
        chk("stall_count", 72'(n_acc - base_acc), 72'(8));
        out_ready = 1'b1;
        send(3'd5, 2'd1, 32'h2008, 32'h3008, 40, ok);
        chk("ninth_accept", 72'(ok), 72'(1'b1));
        send(3'd7, 2'd3, 32'h2009, 32'h3009, 40, ok);
        chk("tenth_accept", 72'(ok), 72'(1'b1));
        wait_drain("burst");
        chk("burst_pops", 72'(n_pop - base_pop), 72'(10));

        // Continuous requests with random output back-pressure.
        rnd = 1'b1;
        base_pop = n_pop;
        n_stuck = 0;
        for (int i = 0; i < 200; i++) begin
            send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom, 60, ok);
            if (!ok) n_stuck++;
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        chk("rand_stuck", 72'(n_stuck), 72'(0));
        wait_drain("rand");
        chk("rand_pops", 72'(n_pop - base_pop), 72'(200));

        // Reset with three operations in flight; a request during reset is ignored.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(3'd1, 2'd2, 32'h5000 + 32'(i), 32'h6000, 10, ok);
            chk("pre_rst_accept", 72'(ok), 72'(1'b1));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b1; in_op = 3'd0; in_opa = 32'h1234; in_opb = 32'h5678;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 72'(out_valid), 72'(1'b0));
        chk("mid_rst_busy", 72'(busy), 72'(1'b0));
        chk("mid_rst_in_ready", 72'(in_ready), 72'(1'b1));
        chk("mid_rst_fpu_opa", 72'(fpu_opa), 72'(32'd0));
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            chk("no_stale", 72'(out_valid), 72'(1'b0));
        end
        @(posedge clk);
        #1;

        // Half and double precision builds: 1.0 + 1.0.
        h16_in_valid = 1'b1;
        h64_in_valid = 1'b1;
        @(posedge clk);
        #1;
        h16_in_valid = 1'b0;
        h64_in_valid = 1'b0;
        r16 = 16'd0; f16 = 8'hff; r64 = 64'd0; f64 = 8'hff;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (h16_out_valid) begin r16 = h16_out_res; f16 = h16_out_flags; end
            if (h64_out_valid) begin r64 = h64_out_res; f64 = h64_out_flags; end
        end
        chk("half_res", 72'(r16), 72'(16'h4000));
        chk("half_flags", 72'(f16), 72'(8'h00));
        chk("double_res", 72'(r64), 72'(64'h4000000000000000));
        chk("double_flags", 72'(f64), 72'(8'h00));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
